dsm_interp_feed: RTL and testbench
==================================

Name: dsm_interp_feed

Overview:
- Upstream feeder for the delta-sigma modulator.
- Accepts 16-bit signed PCM samples at the audio rate over a valid/ready handshake and buffers them in a small FIFO.
- Linearly interpolates between successive samples at oversampling ratio 2^LOG2_OSR.
- Drives a new 20-bit `vin` word every clk, in modulator format: [19:16] headroom/sign, [15] = 1.0 V, [14:0] fraction.

Parameters:
- LOG2_OSR, 2: log2 of the oversampling ratio; OSR = 4 clk cycles per input sample.
- FIFO_DEPTH, 4: input FIFO entries; must be a power of 2 and >= 2.
- CLAMP_LEVEL, 20'h0_6000: magnitude limit (+0.75 V) applied when the optional clamp is compiled in.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_data  in  16  signed PCM sample; 0x7FFF ~ +1.0, 0x8000 = -1.0
- in_valid  in  1  in_data is valid
- in_ready  out  1  FIFO can accept; a sample is pushed when in_valid && in_ready
- clr_underrun  in  1  one-cycle pulse that clears the underrun flag
- vin  out  20  interpolated modulator input, two's complement
- underrun  out  1  sticky: a segment boundary occurred with the FIFO empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- clamp_active  out  1  vin is saturated this cycle

Behaviour:
- Reset (sync, active-high) values:
  - FIFO emptied, fifo_level=0.
  - acc=0, target=0, step=0, k=0, state=IDLE.
  - vin=0, underrun=0, clamp_active=0.
  - in_ready=0 while reset is high; in_ready=1 on the first cycle after reset deasserts.
  - Reset mid-segment abandons the segment; there is no drain.
- Sample format conversion:
  - in_data is sign-extended to 20 bits, so 1.0 = 2^15. 0x4000 -> 20'h0_4000; 0x8000 -> 20'hF_8000.
- Internal registers:
  - acc: signed, 20+LOG2_OSR bits, holds vin*OSR.
  - target: 20 bits, the sample currently being approached.
  - step: 21-bit signed, equal to new - target.
  - k: counter, 0..OSR.
- Output: vin = acc >>> LOG2_OSR (arithmetic, floor), driven directly from registers.
- FIFO:
  - in_ready = !full; there is no combinational path from pop to in_ready.
  - Push and pop in the same cycle: level is unchanged.
  - A push into an empty FIFO is poppable on the next cycle, never the same cycle.
- Segment launch (a pop):
  - Pop sample n.
  - step <= n - target; acc <= acc + (n - target); target <= n; k <= 1; state <= RUN.
- States:
  - IDLE: acc=0. Launch a segment when the FIFO is non-empty.
  - RUN, k<OSR: acc <= acc + step; k <= k+1.
  - RUN, k==OSR (acc == target<<LOG2_OSR exactly):
    - FIFO non-empty: launch the next segment in this cycle, so each sample spans exactly OSR cycles.
    - FIFO empty: underrun <= 1; state <= STARVE.
  - STARVE: acc held, so vin holds target. Launch on the first cycle the FIFO is non-empty.
- Latency: a sample pushed in cycle t is launched at t+1; the first ramp value appears on vin in cycle t+2. The ramp reaches n exactly OSR cycles after launch.
- Underrun flag:
  - Sticky until clr_underrun or reset.
  - If a set event and clr_underrun occur in the same cycle, set wins.
- Arithmetic: accumulation has no drift, because the endpoint is exact by construction. With 16-bit inputs, step fits in 17 bits and no overflow is possible.

Optional Feature:
- Macro: DSM_FEED_CLAMP_EN.
- Defined:
  - vin = min(max(raw, -CLAMP_LEVEL), +CLAMP_LEVEL), registered, which adds 1 cycle of latency to vin.
  - clamp_active is set in the same cycle the clamped value is presented.
  - This keeps the loop filter in its stable input range.
- Undefined:
  - vin = raw, with no extra latency.
  - clamp_active is tied to 0.

Decomposition:
- Shared package dsm_pkg holds:
  - VIN_W=20, PCM_W=16
  - VIN_FS=20'h0_8000, VIN_FS_HALF=20'h0_4000
  - the state enum {IDLE, RUN, STARVE}
- One sub-module: dsm_sample_fifo (synchronous FIFO with full/empty/level). It is parameterised by depth and width and is reusable by other rate-crossing stages.

Test Plan:
- Ramp from reset, OSR=4:
  - Stimulus: push 0x4000 once.
  - vin sequence from t+2: 0x01000, 0x02000, 0x03000, 0x04000.
  - Then underrun=1 and vin holds 0x04000.
- Continuous stream:
  - Stimulus: push 0x4000 then 0xC000 (-0.5) back-to-back.
  - Second segment: 0x02000, 0x00000, 0xFE000, 0xFC000.
  - No underrun; each segment is exactly 4 cycles.
- FIFO backpressure:
  - Stimulus: hold in_valid=1 from IDLE with FIFO_DEPTH=4.
  - in_ready deasserts at level 4 and reasserts the cycle after a pop.
  - No sample is lost or duplicated; checked against a scoreboard.
- Negative full scale:
  - Stimulus: push 0x8000 from 0.
  - vin: 0xFE000, 0xFC000, 0xFA000, 0xF8000 (floor rounding verified).
- Underrun recovery and clear:
  - Starve for 10 cycles, then push 0x2000.
  - vin holds during the starve; the ramp resumes 2 cycles after the push; underrun stays 1.
  - A clr_underrun pulse clears it; a coincident set event wins.
- Reset mid-segment and clamp:
  - Reset at k=2: the next cycle shows vin=0, fifo_level=0, state IDLE.
  - With DSM_FEED_CLAMP_EN defined: push 0x7FFF; vin saturates at 0x06000 with clamp_active=1.

Source files
------------

// File: rtl/dsm_pkg.sv
// rtl/dsm_pkg.sv - shared widths, full-scale constants and feeder state for the delta-sigma input path
package dsm_pkg;

  localparam int VIN_W = 20;
  localparam int PCM_W = 16;

  localparam logic [VIN_W-1:0] VIN_FS      = 20'h0_8000;
  localparam logic [VIN_W-1:0] VIN_FS_HALF = 20'h0_4000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STARVE
  } feed_state_t;

  // PCM full scale maps onto bit 15, so widening is a plain sign extension
  function automatic logic [VIN_W-1:0] pcm_to_vin(input logic [PCM_W-1:0] s);
    return {{(VIN_W-PCM_W){s[PCM_W-1]}}, s};
  endfunction

endpackage

// File: rtl/dsm_sample_fifo.sv
// rtl/dsm_sample_fifo.sv - synchronous FIFO with registered full/empty/level for rate-crossing stages
module dsm_sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // full/empty come only from the level register, so pop never reaches in_ready combinationally
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dsm_interp_feed.sv
// rtl/dsm_interp_feed.sv - PCM FIFO plus linear interpolator feeding vin; DSM_FEED_CLAMP_EN adds a registered output clamp
module dsm_interp_feed
  import dsm_pkg::*;
#(
  parameter int              LOG2_OSR    = 2,
  parameter int              FIFO_DEPTH  = 4,
  parameter logic [19:0]     CLAMP_LEVEL = 20'h0_6000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [15:0]                  in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         clr_underrun,
  output logic [19:0]                  vin,
  output logic                         underrun,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         clamp_active
);

  localparam int ACC_W = VIN_W + LOG2_OSR;
  localparam logic [LOG2_OSR:0] K_END = (LOG2_OSR+1)'(1 << LOG2_OSR);

  if (CLAMP_LEVEL > VIN_FS || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("dsm_interp_feed: illegal CLAMP_LEVEL or FIFO_DEPTH");
  end

  feed_state_t             state, state_nx;
  logic signed [ACC_W-1:0] acc, acc_nx;
  logic signed [VIN_W-1:0] target, target_nx;
  logic signed [VIN_W:0]   step, step_nx;
  logic [LOG2_OSR:0]       k, k_nx;
  logic                    launch;
  logic                    underrun_set;
  logic                    pop;
  logic [PCM_W-1:0]        fifo_rdata;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic signed [VIN_W-1:0] sample;
  logic signed [VIN_W:0]   delta;
  logic signed [VIN_W-1:0] raw;

  assign in_ready = !reset && !fifo_full;

  dsm_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PCM_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid && in_ready),
    .wdata (in_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign sample = pcm_to_vin(fifo_rdata);
  assign delta  = {sample[VIN_W-1], sample} - {target[VIN_W-1], target};
  // acc carries vin*OSR, so dropping the low bits is the floor of the interpolated value
  assign raw    = acc[ACC_W-1:LOG2_OSR];

  always_comb begin
    state_nx     = state;
    acc_nx       = acc;
    target_nx    = target;
    step_nx      = step;
    k_nx         = k;
    launch       = 1'b0;
    underrun_set = 1'b0;
    pop          = 1'b0;
    case (state)
      IDLE, STARVE: launch = !fifo_empty;
      RUN: begin
        if (k == K_END) begin
          if (!fifo_empty) begin
            launch = 1'b1;
          end else begin
            underrun_set = 1'b1;
            state_nx     = STARVE;
          end
        end else begin
          acc_nx = acc + ACC_W'(step);
          k_nx   = k + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // after OSR steps acc equals target*OSR exactly, so the next ramp starts drift-free
    if (launch) begin
      pop       = 1'b1;
      step_nx   = delta;
      acc_nx    = acc + ACC_W'(delta);
      target_nx = sample;
      k_nx      = {{LOG2_OSR{1'b0}}, 1'b1};
      state_nx  = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      target <= '0;
      step   <= '0;
      k      <= '0;
    end else begin
      state  <= state_nx;
      acc    <= acc_nx;
      target <= target_nx;
      step   <= step_nx;
      k      <= k_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)             underrun <= 1'b0;
    else if (underrun_set) underrun <= 1'b1;
    else if (clr_underrun) underrun <= 1'b0;
  end

`ifdef DSM_FEED_CLAMP_EN
  localparam logic signed [VIN_W-1:0] CLAMP_POS = CLAMP_LEVEL;
  localparam logic signed [VIN_W-1:0] CLAMP_NEG = -CLAMP_LEVEL;

  logic [VIN_W-1:0] vin_q;
  logic             clamp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vin_q   <= '0;
      clamp_q <= 1'b0;
    end else if (raw > CLAMP_POS) begin
      vin_q   <= CLAMP_POS;
      clamp_q <= 1'b1;
    end else if (raw < CLAMP_NEG) begin
      vin_q   <= CLAMP_NEG;
      clamp_q <= 1'b1;
    end else begin
      vin_q   <= raw;
      clamp_q <= 1'b0;
    end
  end

  assign vin          = vin_q;
  assign clamp_active = clamp_q;
`else
  assign vin          = raw;
  assign clamp_active = 1'b0;
`endif

endmodule

// File: tb/tb_dsm_interp_feed.sv
// tb/tb_dsm_interp_feed.sv - scoreboard bench: driver queues expected ramps, monitor compares every cycle
module tb_dsm_interp_feed;
  import dsm_pkg::*;

  localparam int OSR   = 4;
  localparam int DEPTH = 4;
  localparam int CLAMP = 'h6000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        clr_underrun = 1'b0;
  logic        in_ready;
  logic [19:0] vin;
  logic        underrun;
  logic [2:0]  fifo_level;
  logic        clamp_active;

  dsm_interp_feed dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .clr_underrun (clr_underrun),
    .vin          (vin),
    .underrun     (underrun),
    .fifo_level   (fifo_level),
    .clamp_active (clamp_active)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int push_cyc_q[$];
  int cyc = 0;
  int cur = 0;
  int shown = 0;
  bit clamp_exp = 1'b0;
  bit und_exp = 1'b0;
  bit check_en = 1'b0;
  int prev = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // interpolated point j of OSR between targets p and n, rounded toward minus infinity
  function automatic int ramp_pt(int p, int n, int j);
    int x;
    int q;
    x = j * (n - p);
    q = (x >= 0) ? x / OSR : -((-x + OSR - 1) / OSR);
    return p + q;
  endfunction

  function automatic int clampf(int v);
    if (v > CLAMP)  return CLAMP;
    if (v < -CLAMP) return -CLAMP;
    return v;
  endfunction

  // reference timeline: a segment lasts OSR cycles, next one starts as soon as a sample
  // accepted in an earlier cycle is waiting; a finished segment with nothing waiting is an underrun
  initial begin
    int  seg_left;
    bit  running;
    bit  set_ev;
    int  pre;
    seg_left = 0;
    running  = 1'b0;
    forever begin
      @(posedge clk);
      set_ev = 1'b0;
      pre    = cur;
      if (reset) begin
        exp_q.delete();
        push_cyc_q.delete();
        cur      = 0;
        pre      = 0;
        seg_left = 0;
        running  = 1'b0;
        und_exp  = 1'b0;
      end else begin
        if (seg_left == 0) begin
          if (push_cyc_q.size() > 0 && push_cyc_q[0] < cyc) begin
            void'(push_cyc_q.pop_front());
            seg_left = OSR;
          end else if (running) begin
            set_ev  = 1'b1;
            running = 1'b0;
          end
        end
        if (seg_left > 0) begin
          cur = exp_q.pop_front();
          seg_left--;
          running = 1'b1;
        end
        if (set_ev)            und_exp = 1'b1;
        else if (clr_underrun) und_exp = 1'b0;
      end
`ifdef DSM_FEED_CLAMP_EN
      shown     = clampf(pre);
      clamp_exp = (clampf(pre) != pre);
`else
      shown     = cur;
      clamp_exp = (pre != pre);
`endif
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        check("vin", int'($signed(vin)), shown);
        check("underrun", int'(underrun), int'(und_exp));
        check("fifo_level", int'(fifo_level), push_cyc_q.size());
        check("in_ready", int'(in_ready), int'(!reset && push_cyc_q.size() < DEPTH));
        check("clamp_active", int'(clamp_active), int'(clamp_exp));
      end
    end
  end

  task automatic drive(bit v, logic [15:0] d, bit clr, bit rst);
    int n;
    @(negedge clk);
    #2;
    reset        = rst;
    in_valid     = v;
    in_data      = d;
    clr_underrun = clr;
    #1;
    if (rst) begin
      prev = 0;
    end else if (v && in_ready) begin
      n = int'($signed(d));
      for (int j = 1; j <= OSR; j++) exp_q.push_back(ramp_pt(prev, n, j));
      push_cyc_q.push_back(cyc);
      prev = n;
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] d;
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    check_en = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    idle(2);
    // single ramp from reset, then underrun with vin holding
    drive(1'b1, 16'(VIN_FS_HALF), 1'b0, 1'b0);
    idle(10);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    idle(2);
    // back-to-back stream
    drive(1'b1, 16'h4000, 1'b0, 1'b0);
    drive(1'b1, 16'hC000, 1'b0, 1'b0);
    idle(12);
    // negative full scale from zero
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    drive(1'b1, 16'(VIN_FS), 1'b0, 1'b0);
    idle(8);
    // long starve, resume, clear coincident with the next underrun set
    idle(10);
    drive(1'b1, 16'h2000, 1'b0, 1'b0);
    idle(4);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    idle(3);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    idle(2);
    // sustained backpressure
    for (int i = 0; i < 40; i++) drive(1'b1, 16'($urandom), 1'b0, 1'b0);
    idle(24);
    // reset while k=2
    drive(1'b1, 16'h3000, 1'b0, 1'b0);
    idle(3);
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    idle(3);
    // positive extreme exercises the clamp when built in
    drive(1'b1, 16'h7FFF, 1'b0, 1'b0);
    idle(8);
    drive(1'b1, 16'h8000, 1'b0, 1'b0);
    idle(8);
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0:       d = 16'h7FFF;
        1:       d = 16'h8000;
        default: d = 16'($urandom);
      endcase
      drive(($urandom_range(0, 3) != 0) ^ (i[6] & i[5]), d,
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 149) == 0));
    end
    idle(12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
